// File: rtl/vga_coord_gen.sv
// Free-running VGA raster generator: pixel coordinates, HS/VS, active-video and frame-start.
// Optional VGA_SYNC_ALIGN_EN delays HS/VS by SYNC_DLY cycles to line up with a registered colour stage.
module vga_coord_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int SYNC_DLY = 2
) (
  input  logic        CLK_VGA,
  input  logic        RESETn,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SYNC_ALIGN_EN
  localparam bit SYNC_ALIGN = 1'b1;
`else
  localparam bit SYNC_ALIGN = 1'b0;
`endif
  localparam int DLY_STAGES = SYNC_ALIGN ? SYNC_DLY : 0;

  function automatic logic in_window(input logic [11:0] x, input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic sync_level(input logic on, input logic pol);
    return on ? pol : ~pol;
  endfunction

  logic        h_wrap;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        hs_p0;
  logic        vs_p0;

  always_comb begin
    h_wrap = (VGA_horzCoord == H_LAST);
    h_nxt  = h_wrap ? 12'd0 : VGA_horzCoord + 12'd1;
    v_nxt  = VGA_vertCoord;
    if (h_wrap)
      v_nxt = (VGA_vertCoord == V_LAST) ? 12'd0 : VGA_vertCoord + 12'd1;
  end

  // Stage p0: counters plus flags decoded from the next counter values, so all stay aligned
  always_ff @(posedge CLK_VGA) begin
    if (!RESETn) begin
      VGA_horzCoord <= H_LAST;
      VGA_vertCoord <= V_LAST;
      VGA_active    <= 1'b0;
      frame_start   <= 1'b0;
      hs_p0         <= ~H_POL;
      vs_p0         <= ~V_POL;
    end else begin
      VGA_horzCoord <= h_nxt;
      VGA_vertCoord <= v_nxt;
      VGA_active    <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      frame_start   <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
      hs_p0         <= sync_level(in_window(h_nxt, H_SYNC_BEG, H_SYNC_END), H_POL);
      vs_p0         <= sync_level(in_window(v_nxt, V_SYNC_BEG, V_SYNC_END), V_POL);
    end
  end

  // Stage p1..: optional sync delay line, cleared to inactive levels on reset
  if (DLY_STAGES > 0) begin : g_sync_dly
    logic [DLY_STAGES-1:0] hs_dly_p1;
    logic [DLY_STAGES-1:0] vs_dly_p1;

    always_ff @(posedge CLK_VGA) begin
      if (!RESETn) begin
        hs_dly_p1 <= {DLY_STAGES{~H_POL}};
        vs_dly_p1 <= {DLY_STAGES{~V_POL}};
      end else begin
        hs_dly_p1[0] <= hs_p0;
        vs_dly_p1[0] <= vs_p0;
        for (int i = 1; i < DLY_STAGES; i++) begin
          hs_dly_p1[i] <= hs_dly_p1[i-1];
          vs_dly_p1[i] <= vs_dly_p1[i-1];
        end
      end
    end

    assign VGA_HS = hs_dly_p1[DLY_STAGES-1];
    assign VGA_VS = vs_dly_p1[DLY_STAGES-1];
  end else begin : g_sync_direct
    assign VGA_HS = hs_p0;
    assign VGA_VS = vs_p0;
  end

endmodule

// File: tb/tb_vga_coord_gen.sv
// Bench for vga_coord_gen: a full-size instance checked over its first lines and a small
// raster instance (inverted sync polarity) checked over whole frames, both against a scoreboard.
module tb_vga_coord_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, dly;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int h, v;
    logic [7:0] hh, vh;
  } mstate_t;

  typedef struct {
    logic [11:0] h, v;
    logic hs, vs, act, fs;
  } exp_t;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int A_DLY = 2;
  localparam int B_DLY = 3;
`else
  localparam int A_DLY = 0;
  localparam int B_DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [11:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_vs, a_act, a_fs, b_hs, b_vs, b_act, b_fs;

  int n_assert = 0;
  int n_fail   = 0;

  cfg_t ca, cb;
  mstate_t ma, mb;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  vga_coord_gen u_a (
    .CLK_VGA(clk), .RESETn(rst_a),
    .VGA_horzCoord(a_h), .VGA_vertCoord(a_v),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_active(a_act), .frame_start(a_fs)
  );

  vga_coord_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(3)
  ) u_b (
    .CLK_VGA(clk), .RESETn(rst_b),
    .VGA_horzCoord(b_h), .VGA_vertCoord(b_v),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_active(b_act), .frame_start(b_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference raster: coordinates advance, flags decoded from the current coordinate
  task automatic model_step(input cfg_t c, input logic rst_n, inout mstate_t m, output exp_t e);
    int ht, vt;
    bit hs_on, vs_on;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (!rst_n) begin
      m.h = ht - 1;
      m.v = vt - 1;
    end else if (m.h == ht - 1) begin
      m.h = 0;
      m.v = (m.v == vt - 1) ? 0 : m.v + 1;
    end else begin
      m.h = m.h + 1;
    end
    hs_on = (m.h >= c.ha + c.hf) && (m.h < c.ha + c.hf + c.hs);
    vs_on = (m.v >= c.va + c.vf) && (m.v < c.va + c.vf + c.vs);
    m.hh = {m.hh[6:0], hs_on ? c.hp : ~c.hp};
    m.vh = {m.vh[6:0], vs_on ? c.vp : ~c.vp};
    if (!rst_n) begin
      m.hh = {8{~c.hp}};
      m.vh = {8{~c.vp}};
    end
    e.h   = 12'(m.h);
    e.v   = 12'(m.v);
    e.hs  = m.hh[c.dly];
    e.vs  = m.vh[c.dly];
    e.act = (m.h < c.ha) && (m.v < c.va);
    e.fs  = (m.h == 0) && (m.v == 0);
  endtask

  task automatic tick();
    exp_t ea, eb;
    @(posedge clk);
    model_step(ca, rst_a, ma, ea);
    q_a.push_back(ea);
    model_step(cb, rst_b, mb, eb);
    q_b.push_back(eb);
    @(negedge clk);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check("a_h", a_h, ea.h);     check("a_v", a_v, ea.v);
    check("a_hs", a_hs, ea.hs);  check("a_vs", a_vs, ea.vs);
    check("a_act", a_act, ea.act); check("a_fs", a_fs, ea.fs);
    check("b_h", b_h, eb.h);     check("b_v", b_v, eb.v);
    check("b_hs", b_hs, eb.hs);  check("b_vs", b_vs, eb.vs);
    check("b_act", b_act, eb.act); check("b_fs", b_fs, eb.fs);
  endtask

  initial begin
    int hs_cnt, hs_first, act_fall, since, vcnt, nfr;
    bit reached;
    ca = '{ha:1280, hf:48, hs:112, hb:248, va:1024, vf:1, vs:3, vb:38, dly:A_DLY, hp:1'b1, vp:1'b1};
    cb = '{ha:16, hf:2, hs:3, hb:4, va:6, vf:1, vs:2, vb:3, dly:B_DLY, hp:1'b0, vp:1'b0};
    ma = '{h:0, v:0, hh:8'h00, vh:8'h00};
    mb = '{h:0, v:0, hh:8'h00, vh:8'h00};
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 10; i++) tick();
    check("rst_a_h", a_h, 1687);   check("rst_a_v", a_v, 1065);
    check("rst_a_act", a_act, 0);  check("rst_a_hs", a_hs, 0);
    check("rst_a_vs", a_vs, 0);    check("rst_a_fs", a_fs, 0);
    check("rst_b_h", b_h, 24);     check("rst_b_v", b_v, 11);
    check("rst_b_hs", b_hs, 1);    check("rst_b_vs", b_vs, 1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    check("first_h", a_h, 0);      check("first_v", a_v, 0);
    check("first_act", a_act, 1);  check("first_fs", a_fs, 1);
    check("first_b_fs", b_fs, 1);

    hs_cnt = 0; hs_first = -1; act_fall = -1;
    for (int i = 1; i < 1688; i++) begin
      tick();
      if (i == 1) check("fs_one_cycle", a_fs, 0);
      if (a_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = a_h;
      end
      if (a_act === 1'b0 && act_fall < 0) act_fall = a_h;
    end
    tick();
    check("line_wrap_h", a_h, 0);
    check("line_wrap_v", a_v, 1);
    check("hs_width", hs_cnt, 112);
    check("hs_rise_h", hs_first, 1328 + A_DLY);
    check("act_fall_h", act_fall, 1280);

    reached = 1'b0;
    for (int i = 0; i < 4000 && !reached; i++) begin
      if (a_h == 12'd600 && a_v == 12'd1) reached = 1'b1;
      else tick();
    end
    check("a_reach_mid", reached, 1);
    rst_a = 1'b0;
    tick();
    check("mid_rst_a_h", a_h, 1687); check("mid_rst_a_v", a_v, 1065);
    check("mid_rst_a_hs", a_hs, 0);  check("mid_rst_a_act", a_act, 0);
    rst_a = 1'b1;
    tick();
    check("mid_rel_a_h", a_h, 0);    check("mid_rel_a_fs", a_fs, 1);

    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (b_h == 12'd10 && b_v == 12'd3) reached = 1'b1;
      else tick();
    end
    check("b_reach_mid", reached, 1);
    rst_b = 1'b0;
    tick();
    check("mid_rst_b_h", b_h, 24);   check("mid_rst_b_v", b_v, 11);
    rst_b = 1'b1;
    tick();
    check("mid_rel_b_fs", b_fs, 1);

    since = 0; vcnt = 0; nfr = 0;
    for (int i = 0; i < 950; i++) begin
      tick();
      since++;
      if (b_fs === 1'b1) begin
        check("b_frame_period", since, 300);
        check("b_vs_cycles", vcnt, 50);
        nfr++;
        since = 0;
        vcnt = 0;
      end
      if (b_vs === 1'b0) vcnt++;
    end
    check("b_frames_seen", nfr, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
